mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised memory-access pipeline stage sitting between EX and WB. Accepts load/store/ALU results from EX, runs a valid/ack handshake with a wait-state data memory, and produces the registered write-back bundle. Also drives the MEM forwarding path and stalls upstream while an access is outstanding. Adds over the previous MEM stage:
- XLEN 32/64 generality;
- active-high byte enables;
- offset-aligned load extraction;
- misalignment and unsupported-size detection.

## Interface

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 14, word-address width presented to data memory.
- NB = XLEN/8, derived, bytes per word; OFS_W = log2(NB), derived, byte-offset bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ex_valid  in  1  EX bundle valid this cycle.
- ex_pc  in  XLEN  link value (pc+4) for jumps.
- ex_alu_res  in  XLEN  ALU result or effective byte address.
- ex_rs2  in  XLEN  store data.
- ex_rd_addr  in  5  destination register.
- ex_func3  in  3  access size/sign.
- ex_reg_w, ex_wb_sel, ex_rd_src, ex_mem_r, ex_mem_w  in  1 each  control bits.
- stall  out  1  hold EX and earlier stages.
- dm_req  out  1  memory request valid.
- dm_we  out  1  1 = write.
- dm_be  out  NB  active-high byte enables.
- dm_addr  out  ADDR_W  word address = byte address [OFS_W+ADDR_W-1:OFS_W].
- dm_wdata  out  XLEN  byte-lane-aligned store data.
- dm_ack  in  1  transfer complete; dm_rdata is valid in this cycle for reads.
- dm_rdata  in  XLEN  read data.
- wb_valid, wb_reg_w, wb_sel  out  1 each  registered to WB.
- wb_rd_addr  out  5  registered to WB.
- wb_rd_from_pc, wb_rd_from_mem  out  XLEN  registered to WB.
- wb_exc  out  2  registered exception code: 00 none, 01 misaligned, 10 unsupported size.
- wb_exc_addr  out  XLEN  faulting byte address.
- fwd_valid  out  1  forwarding data valid.
- fwd_data  out  XLEN  forwarding data.

## Operation

State machine:
- IDLE
  - ex_valid and not (mem_r or mem_w): pass-through. WB registers load on the clock edge; wb_rd_from_pc = ex_rd_src ? ex_pc : ex_alu_res. stall = 0.
  - ex_valid with a legal, aligned memory op: latch addr/be/wdata/we/func3/offset/rd/control into the request registers. Go to REQ. stall = 1.
  - ex_valid with an illegal or misaligned memory op: no request. Write WB with wb_reg_w = 0, wb_exc set, wb_exc_addr = ex_alu_res. stall = 0.
  - ex_valid = 0: wb_valid <= 0.
- REQ: dm_req = 1 from registers; all dm_* outputs held stable.
  - dm_ack = 0: stay in REQ, stall = 1.
  - dm_ack = 1: stall = 0. Write WB with wb_rd_from_mem = extended load (0 for stores) and wb_valid = 1. Go to IDLE.

Size and alignment rules (offset o = ex_alu_res[OFS_W-1:0]):
- func3 000 LB/SB, 100 LBU: any offset.
- 001 LH/SH, 101 LHU: misaligned if o[0] = 1.
- 010 LW/SW: misaligned if o[1:0] ≠ 0.
- 110 LWU, 011 LD/SD: legal only when XLEN = 64; LD/SD misaligned if o[2:0] ≠ 0.
- Stores accept only func3 000/001/010/011.
- Any other combination is unsupported size (code 10). Unsupported takes priority over misaligned.

Datapath:
- Store: dm_be = size mask (1/3/F/FF) << o. dm_wdata = ex_rs2 << (8*o).
- Load: rdata is shifted right by 8*o, then sign- or zero-extended per func3 to XLEN.
- Forwarding:
  - IDLE pass-through: fwd_valid = ex_valid, fwd_data = rd_src mux.
  - REQ with a load and dm_ack: fwd_valid = 1, fwd_data = extended load.
  - Otherwise fwd_valid = 0.
- dm_ack while dm_req = 0 is ignored.

## Timing

- Reset (rst sampled high at a clock edge): state goes to IDLE. Every output register clears to 0: dm_req, dm_we, dm_be, dm_addr, dm_wdata, all wb_*. stall and fwd_* evaluate to 0 once rst is released with ex_valid = 0.
- Reset during REQ abandons the access; dm_req is 0 from the next cycle.
- Memory-op latency: accept cycle, then N ≥ 1 REQ cycles, with WB valid on the edge that ends the ack cycle. With zero-wait memory (ack in first REQ cycle) stall is high for exactly 1 cycle.
- Non-memory ops and exceptions: 1-cycle latency, no stall.
- EX must hold its bundle while stall = 1. The stage samples EX only in IDLE.
- Back-to-back memory ops: the second is accepted in the cycle after ack.

## Test plan

- XLEN=32, SB, addr 0x0000_1003, rs2=0x0000_00A5, ack after 2 wait cycles. Required: dm_be=1000, dm_wdata=0xA500_0000, dm_addr=0x400, stall high for 3 cycles, wb_reg_w=0.
- LH, addr 0x2002, rdata=0x8123_4567 with immediate ack. Required: wb_rd_from_mem=0xFFFF_8123 and fwd_data=0xFFFF_8123 in the ack cycle. Repeat as LHU: 0x0000_8123.
- LW at addr 0x2001. Required: no dm_req, stall=0, wb_exc=01, wb_exc_addr=0x2001, wb_reg_w=0.
- XLEN=64: LD at 0x18 returns rdata unchanged; LWU at 0x1C with rdata 0xDEAD_BEEF_0000_0000 gives 0x0000_0000_DEAD_BEEF. XLEN=32: LD gives wb_exc=10.
- ALU op with rd_src=1, pc=0x104 followed by an LW. Required: WB gets 0x104 after 1 cycle, and the LW is accepted without a bubble.
- rst asserted in REQ with dm_ack=0. Required: dm_req=0 and all wb_* = 0 next cycle, state IDLE; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load/store handshake with a wait-state data memory,
// registered write-back bundle, MEM forwarding and upstream stall.
module mem_stage_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [XLEN-1:0]     ex_alu_res,
    input  logic [XLEN-1:0]     ex_rs2,
    input  logic [4:0]          ex_rd_addr,
    input  logic [2:0]          ex_func3,
    input  logic                ex_reg_w,
    input  logic                ex_wb_sel,
    input  logic                ex_rd_src,
    input  logic                ex_mem_r,
    input  logic                ex_mem_w,
    output logic                stall,
    output logic                dm_req,
    output logic                dm_we,
    output logic [XLEN/8-1:0]   dm_be,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [XLEN-1:0]     dm_wdata,
    input  logic                dm_ack,
    input  logic [XLEN-1:0]     dm_rdata,
    output logic                wb_valid,
    output logic                wb_reg_w,
    output logic                wb_sel,
    output logic [4:0]          wb_rd_addr,
    output logic [XLEN-1:0]     wb_rd_from_pc,
    output logic [XLEN-1:0]     wb_rd_from_mem,
    output logic [1:0]          wb_exc,
    output logic [XLEN-1:0]     wb_exc_addr,
    output logic                fwd_valid,
    output logic [XLEN-1:0]     fwd_data
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t state_q, state_d;

    // Request registers
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [NB-1:0]     dm_be_q, dm_be_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [XLEN-1:0]   dm_wdata_q, dm_wdata_d;
    logic [2:0]        func3_q, func3_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_w_q, reg_w_d;
    logic              req_wb_sel_q, req_wb_sel_d;

    // Write-back registers
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_w_q, wb_reg_w_d;
    logic              wb_sel_q, wb_sel_d;
    logic [4:0]        wb_rd_addr_q, wb_rd_addr_d;
    logic [XLEN-1:0]   wb_rd_from_pc_q, wb_rd_from_pc_d;
    logic [XLEN-1:0]   wb_rd_from_mem_q, wb_rd_from_mem_d;
    logic [1:0]        wb_exc_q, wb_exc_d;
    logic [XLEN-1:0]   wb_exc_addr_q, wb_exc_addr_d;

    // EX-side decode
    logic [OFS_W-1:0]  ex_ofs;
    logic [1:0]        ex_sz;
    logic              is_mem;
    logic              unsupported;
    logic              misaligned;
    logic [OFS_W-1:0]  align_mask;
    logic [NB-1:0]     size_mask;
    logic [XLEN-1:0]   pass_data;

    always_comb begin
        ex_ofs      = ex_alu_res[OFS_W-1:0];
        ex_sz       = ex_func3[1:0];
        is_mem      = ex_mem_r | ex_mem_w;
        unsupported = 1'b0;
        if (ex_mem_w) begin
            if (ex_func3[2]) begin
                unsupported = 1'b1;
            end else if (ex_sz == 2'b11 && XLEN != 64) begin
                unsupported = 1'b1;
            end
        end else begin
            if (ex_func3 == 3'b111) begin
                unsupported = 1'b1;
            end else if ((ex_func3 == 3'b011 || ex_func3 == 3'b110) && XLEN != 64) begin
                unsupported = 1'b1;
            end
        end
        align_mask = '0;
        for (int unsigned i = 0; i < OFS_W; i++) begin
            align_mask[i] = (i < 32'(ex_sz));
        end
        size_mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            size_mask[i] = (i < (32'd1 << ex_sz));
        end
        misaligned = |(ex_ofs & align_mask);
        pass_data  = ex_rd_src ? ex_pc : ex_alu_res;
    end

    // Load extraction: align the addressed bytes to bit 0, then extend.
    logic [XLEN-1:0]   rdata_sh;
    logic [XLEN-1:0]   load_ext;
    logic              fill;
    logic [31:0]       ext_w;

    always_comb begin
        rdata_sh = dm_rdata >> {ofs_q, 3'b000};
        ext_w    = 32'd8 << func3_q[1:0];
        case (func3_q[1:0])
            2'b00:   fill = rdata_sh[7];
            2'b01:   fill = rdata_sh[15];
            2'b10:   fill = rdata_sh[31];
            default: fill = 1'b0;
        endcase
        if (func3_q[2]) begin
            fill = 1'b0;
        end
        load_ext = rdata_sh;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i >= ext_w) begin
                load_ext[i] = fill;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        dm_req_d         = dm_req_q;
        dm_we_d          = dm_we_q;
        dm_be_d          = dm_be_q;
        dm_addr_d        = dm_addr_q;
        dm_wdata_d       = dm_wdata_q;
        func3_d          = func3_q;
        ofs_d            = ofs_q;
        rd_d             = rd_q;
        reg_w_d          = reg_w_q;
        req_wb_sel_d     = req_wb_sel_q;
        wb_valid_d       = 1'b0;
        wb_reg_w_d       = wb_reg_w_q;
        wb_sel_d         = wb_sel_q;
        wb_rd_addr_d     = wb_rd_addr_q;
        wb_rd_from_pc_d  = wb_rd_from_pc_q;
        wb_rd_from_mem_d = wb_rd_from_mem_q;
        wb_exc_d         = wb_exc_q;
        wb_exc_addr_d    = wb_exc_addr_q;
        stall            = 1'b0;
        fwd_valid        = 1'b0;
        fwd_data         = '0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d       = 1'b1;
                        wb_reg_w_d       = ex_reg_w;
                        wb_sel_d         = ex_wb_sel;
                        wb_rd_addr_d     = ex_rd_addr;
                        wb_rd_from_pc_d  = pass_data;
                        wb_rd_from_mem_d = '0;
                        wb_exc_d         = 2'b00;
                        wb_exc_addr_d    = '0;
                        fwd_valid        = 1'b1;
                        fwd_data         = pass_data;
                    end else if (unsupported || misaligned) begin
                        wb_valid_d       = 1'b1;
                        wb_reg_w_d       = 1'b0;
                        wb_sel_d         = ex_wb_sel;
                        wb_rd_addr_d     = ex_rd_addr;
                        wb_rd_from_pc_d  = '0;
                        wb_rd_from_mem_d = '0;
                        wb_exc_d         = unsupported ? 2'b10 : 2'b01;
                        wb_exc_addr_d    = ex_alu_res;
                    end else begin
                        state_d      = S_REQ;
                        dm_req_d     = 1'b1;
                        dm_we_d      = ex_mem_w;
                        dm_be_d      = size_mask << ex_ofs;
                        dm_addr_d    = ex_alu_res[OFS_W+ADDR_W-1:OFS_W];
                        dm_wdata_d   = ex_mem_w ? (ex_rs2 << {ex_ofs, 3'b000}) : '0;
                        func3_d      = ex_func3;
                        ofs_d        = ex_ofs;
                        rd_d         = ex_rd_addr;
                        reg_w_d      = ex_reg_w;
                        req_wb_sel_d = ex_wb_sel;
                        stall        = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (dm_ack) begin
                    state_d          = S_IDLE;
                    dm_req_d         = 1'b0;
                    wb_valid_d       = 1'b1;
                    wb_reg_w_d       = reg_w_q;
                    wb_sel_d         = req_wb_sel_q;
                    wb_rd_addr_d     = rd_q;
                    wb_rd_from_pc_d  = '0;
                    wb_rd_from_mem_d = dm_we_q ? '0 : load_ext;
                    wb_exc_d         = 2'b00;
                    wb_exc_addr_d    = '0;
                    if (!dm_we_q) begin
                        fwd_valid = 1'b1;
                        fwd_data  = load_ext;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            dm_req_q         <= 1'b0;
            dm_we_q          <= 1'b0;
            dm_be_q          <= '0;
            dm_addr_q        <= '0;
            dm_wdata_q       <= '0;
            func3_q          <= '0;
            ofs_q            <= '0;
            rd_q             <= '0;
            reg_w_q          <= 1'b0;
            req_wb_sel_q     <= 1'b0;
            wb_valid_q       <= 1'b0;
            wb_reg_w_q       <= 1'b0;
            wb_sel_q         <= 1'b0;
            wb_rd_addr_q     <= '0;
            wb_rd_from_pc_q  <= '0;
            wb_rd_from_mem_q <= '0;
            wb_exc_q         <= '0;
            wb_exc_addr_q    <= '0;
        end else begin
            state_q          <= state_d;
            dm_req_q         <= dm_req_d;
            dm_we_q          <= dm_we_d;
            dm_be_q          <= dm_be_d;
            dm_addr_q        <= dm_addr_d;
            dm_wdata_q       <= dm_wdata_d;
            func3_q          <= func3_d;
            ofs_q            <= ofs_d;
            rd_q             <= rd_d;
            reg_w_q          <= reg_w_d;
            req_wb_sel_q     <= req_wb_sel_d;
            wb_valid_q       <= wb_valid_d;
            wb_reg_w_q       <= wb_reg_w_d;
            wb_sel_q         <= wb_sel_d;
            wb_rd_addr_q     <= wb_rd_addr_d;
            wb_rd_from_pc_q  <= wb_rd_from_pc_d;
            wb_rd_from_mem_q <= wb_rd_from_mem_d;
            wb_exc_q         <= wb_exc_d;
            wb_exc_addr_q    <= wb_exc_addr_d;
        end
    end

    assign dm_req         = dm_req_q;
    assign dm_we          = dm_we_q;
    assign dm_be          = dm_be_q;
    assign dm_addr        = dm_addr_q;
    assign dm_wdata       = dm_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_reg_w       = wb_reg_w_q;
    assign wb_sel         = wb_sel_q;
    assign wb_rd_addr     = wb_rd_addr_q;
    assign wb_rd_from_pc  = wb_rd_from_pc_q;
    assign wb_rd_from_mem = wb_rd_from_mem_q;
    assign wb_exc         = wb_exc_q;
    assign wb_exc_addr    = wb_exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 32-bit and a 64-bit instance share stimulus.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_alu_res, ex_rs2;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_func3;
    logic        ex_reg_w, ex_wb_sel, ex_rd_src, ex_mem_r, ex_mem_w;
    logic        dm_ack;
    logic [63:0] dm_rdata;

    logic        stall32, dm_req32, dm_we32, wb_valid32, wb_reg_w32, wb_sel32, fwd_valid32;
    logic [3:0]  dm_be32;
    logic [13:0] dm_addr32;
    logic [31:0] dm_wdata32, wb_rd_from_pc32, wb_rd_from_mem32, wb_exc_addr32, fwd_data32;
    logic [4:0]  wb_rd_addr32;
    logic [1:0]  wb_exc32;

    logic        stall64, dm_req64, dm_we64, wb_valid64, wb_reg_w64, wb_sel64, fwd_valid64;
    logic [7:0]  dm_be64;
    logic [13:0] dm_addr64;
    logic [63:0] dm_wdata64, wb_rd_from_pc64, wb_rd_from_mem64, wb_exc_addr64, fwd_data64;
    logic [4:0]  wb_rd_addr64;
    logic [1:0]  wb_exc64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .ADDR_W(14)) dut32 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .ex_pc(ex_pc[31:0]), .ex_alu_res(ex_alu_res[31:0]), .ex_rs2(ex_rs2[31:0]),
        .ex_rd_addr(ex_rd_addr), .ex_func3(ex_func3), .ex_reg_w(ex_reg_w),
        .ex_wb_sel(ex_wb_sel), .ex_rd_src(ex_rd_src), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
        .stall(stall32), .dm_req(dm_req32), .dm_we(dm_we32), .dm_be(dm_be32),
        .dm_addr(dm_addr32), .dm_wdata(dm_wdata32), .dm_ack(dm_ack), .dm_rdata(dm_rdata[31:0]),
        .wb_valid(wb_valid32), .wb_reg_w(wb_reg_w32), .wb_sel(wb_sel32), .wb_rd_addr(wb_rd_addr32),
        .wb_rd_from_pc(wb_rd_from_pc32), .wb_rd_from_mem(wb_rd_from_mem32), .wb_exc(wb_exc32),
        .wb_exc_addr(wb_exc_addr32), .fwd_valid(fwd_valid32), .fwd_data(fwd_data32)
    );

    mem_stage_lsu #(.XLEN(64), .ADDR_W(14)) dut64 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_alu_res(ex_alu_res), .ex_rs2(ex_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_func3(ex_func3), .ex_reg_w(ex_reg_w),
        .ex_wb_sel(ex_wb_sel), .ex_rd_src(ex_rd_src), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
        .stall(stall64), .dm_req(dm_req64), .dm_we(dm_we64), .dm_be(dm_be64),
        .dm_addr(dm_addr64), .dm_wdata(dm_wdata64), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid64), .wb_reg_w(wb_reg_w64), .wb_sel(wb_sel64), .wb_rd_addr(wb_rd_addr64),
        .wb_rd_from_pc(wb_rd_from_pc64), .wb_rd_from_mem(wb_rd_from_mem64), .wb_exc(wb_exc64),
        .wb_exc_addr(wb_exc_addr64), .fwd_valid(fwd_valid64), .fwd_data(fwd_data64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [63:0] alu, input logic [63:0] rs2, input logic [4:0] rd,
                         input logic regw, input logic rdsrc, input logic [63:0] pc);
        ex_valid   = v;
        ex_mem_r   = mr;
        ex_mem_w   = mw;
        ex_func3   = f3;
        ex_alu_res = alu;
        ex_rs2     = rs2;
        ex_rd_addr = rd;
        ex_reg_w   = regw;
        ex_rd_src  = rdsrc;
        ex_pc      = pc;
        ex_wb_sel  = mr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if ({dm_req32, dm_we32, dm_be32, dm_addr32, dm_wdata32, wb_valid32, wb_reg_w32, wb_sel32,
                      wb_rd_addr32, wb_rd_from_pc32, wb_rd_from_mem32, wb_exc32, wb_exc_addr32} !== '0) begin
            n_err++; $display("FAIL reset_regs32: some output register nonzero (dm_req=%b wb_valid=%b)", dm_req32, wb_valid32);
        end
        n_cmp++; if ({dm_req64, dm_we64, dm_be64, dm_addr64, dm_wdata64, wb_valid64, wb_reg_w64, wb_sel64,
                      wb_rd_addr64, wb_rd_from_pc64, wb_rd_from_mem64, wb_exc64, wb_exc_addr64} !== '0) begin
            n_err++; $display("FAIL reset_regs64: some output register nonzero (dm_req=%b wb_valid=%b)", dm_req64, wb_valid64);
        end
        n_cmp++; if ({stall32, fwd_valid32, fwd_data32, stall64, fwd_valid64, fwd_data64} !== '0) begin
            n_err++; $display("FAIL reset_comb: stall32=%b fwd_valid32=%b stall64=%b fwd_valid64=%b want 0",
                              stall32, fwd_valid32, stall64, fwd_valid64);
        end
        step();
    endtask

    task automatic test_store_byte();
        int stall_cycles = 0;
        drive(1'b1, 1'b0, 1'b1, 3'b000, 64'h1003, 64'hA5, 5'd0, 1'b0, 1'b0, 64'h0);
        #1;
        if (stall32) stall_cycles++;
        step();
        ex_valid = 1'b0;
        n_cmp++; if (dm_req32 !== 1'b1 || dm_we32 !== 1'b1) begin
            n_err++; $display("FAIL sb_req: got req=%b we=%b want 1 1", dm_req32, dm_we32);
        end
        n_cmp++; if (dm_be32 !== 4'b1000) begin
            n_err++; $display("FAIL sb_be: got %b want 1000", dm_be32);
        end
        n_cmp++; if (dm_wdata32 !== 32'hA500_0000) begin
            n_err++; $display("FAIL sb_wdata: got %h want a5000000", dm_wdata32);
        end
        n_cmp++; if (dm_addr32 !== 14'h400) begin
            n_err++; $display("FAIL sb_addr: got %h want 400", dm_addr32);
        end
        for (int i = 0; i < 3; i++) begin
            dm_ack = (i == 2);
            #1;
            if (stall32) stall_cycles++;
            step();
        end
        dm_ack = 1'b0;
        n_cmp++; if (stall_cycles !== 3) begin
            n_err++; $display("FAIL sb_stall_cycles: got %0d want 3", stall_cycles);
        end
        n_cmp++; if (wb_valid32 !== 1'b1 || wb_reg_w32 !== 1'b0 || wb_exc32 !== 2'b00 || dm_req32 !== 1'b0) begin
            n_err++; $display("FAIL sb_wb: got valid=%b reg_w=%b exc=%b req=%b want 1 0 00 0",
                              wb_valid32, wb_reg_w32, wb_exc32, dm_req32);
        end
    endtask

    task automatic test_load_half(input logic [2:0] f3, input logic [31:0] expv);
        drive(1'b1, 1'b1, 1'b0, f3, 64'h2002, 64'h0, 5'd5, 1'b1, 1'b0, 64'h0);
        #1;
        n_cmp++; if (stall32 !== 1'b1) begin
            n_err++; $display("FAIL lh_accept_stall f3=%b: got %b want 1", f3, stall32);
        end
        step();
        ex_valid = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = 64'h0000_0000_8123_4567;
        #1;
        n_cmp++; if (fwd_valid32 !== 1'b1 || fwd_data32 !== expv || stall32 !== 1'b0) begin
            n_err++; $display("FAIL lh_fwd f3=%b: got valid=%b data=%h stall=%b want 1 %h 0",
                              f3, fwd_valid32, fwd_data32, stall32, expv);
        end
        step();
        dm_ack = 1'b0;
        n_cmp++; if (wb_valid32 !== 1'b1 || wb_rd_from_mem32 !== expv || wb_rd_addr32 !== 5'd5 || wb_reg_w32 !== 1'b1) begin
            n_err++; $display("FAIL lh_wb f3=%b: got valid=%b data=%h rd=%0d reg_w=%b want 1 %h 5 1",
                              f3, wb_valid32, wb_rd_from_mem32, wb_rd_addr32, wb_reg_w32, expv);
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h2001, 64'h0, 5'd7, 1'b1, 1'b0, 64'h0);
        #1;
        n_cmp++; if (stall32 !== 1'b0 || stall64 !== 1'b0) begin
            n_err++; $display("FAIL mis_stall: got %b/%b want 0/0", stall32, stall64);
        end
        step();
        ex_valid = 1'b0;
        n_cmp++; if (dm_req32 !== 1'b0) begin
            n_err++; $display("FAIL mis_req: got %b want 0", dm_req32);
        end
        n_cmp++; if (wb_exc32 !== 2'b01 || wb_exc_addr32 !== 32'h2001 || wb_reg_w32 !== 1'b0 || wb_valid32 !== 1'b1) begin
            n_err++; $display("FAIL mis_wb: got exc=%b addr=%h reg_w=%b valid=%b want 01 2001 0 1",
                              wb_exc32, wb_exc_addr32, wb_reg_w32, wb_valid32);
        end
        step();
    endtask

    task automatic test_xlen64_loads();
        // LD at 0x18: 64-bit completes, 32-bit flags unsupported size
        drive(1'b1, 1'b1, 1'b0, 3'b011, 64'h18, 64'h0, 5'd9, 1'b1, 1'b0, 64'h0);
        step();
        ex_valid = 1'b0;
        n_cmp++; if (wb_exc32 !== 2'b10 || wb_exc_addr32 !== 32'h18 || wb_reg_w32 !== 1'b0) begin
            n_err++; $display("FAIL ld32_exc: got exc=%b addr=%h reg_w=%b want 10 18 0", wb_exc32, wb_exc_addr32, wb_reg_w32);
        end
        n_cmp++; if (dm_req64 !== 1'b1 || dm_addr64 !== 14'h3 || dm_be64 !== 8'hFF) begin
            n_err++; $display("FAIL ld64_req: got req=%b addr=%h be=%h want 1 3 ff", dm_req64, dm_addr64, dm_be64);
        end
        dm_ack   = 1'b1;
        dm_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        dm_ack = 1'b0;
        n_cmp++; if (wb_rd_from_mem64 !== 64'h0123_4567_89AB_CDEF) begin
            n_err++; $display("FAIL ld64_wb: got %h want 0123456789abcdef", wb_rd_from_mem64);
        end
        drive(1'b1, 1'b1, 1'b0, 3'b110, 64'h1C, 64'h0, 5'd10, 1'b1, 1'b0, 64'h0);
        step();
        ex_valid = 1'b0;
        n_cmp++; if (wb_exc32 !== 2'b10) begin
            n_err++; $display("FAIL lwu32_exc: got %b want 10", wb_exc32);
        end
        n_cmp++; if (dm_be64 !== 8'hF0) begin
            n_err++; $display("FAIL lwu64_be: got %h want f0", dm_be64);
        end
        dm_ack   = 1'b1;
        dm_rdata = 64'hDEAD_BEEF_0000_0000;
        #1;
        n_cmp++; if (fwd_valid64 !== 1'b1 || fwd_data64 !== 64'h0000_0000_DEAD_BEEF) begin
            n_err++; $display("FAIL lwu64_fwd: got valid=%b data=%h want 1 00000000deadbeef", fwd_valid64, fwd_data64);
        end
        step();
        dm_ack = 1'b0;
        n_cmp++; if (wb_rd_from_mem64 !== 64'h0000_0000_DEAD_BEEF) begin
            n_err++; $display("FAIL lwu64_wb: got %h want 00000000deadbeef", wb_rd_from_mem64);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'h55, 64'h0, 5'd3, 1'b1, 1'b1, 64'h104);
        #1;
        n_cmp++; if (stall32 !== 1'b0 || fwd_valid32 !== 1'b1 || fwd_data32 !== 32'h104) begin
            n_err++; $display("FAIL alu_fwd: got stall=%b valid=%b data=%h want 0 1 104", stall32, fwd_valid32, fwd_data32);
        end
        step();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h2000, 64'h0, 5'd4, 1'b1, 1'b0, 64'h0);
        #1;
        n_cmp++; if (wb_valid32 !== 1'b1 || wb_rd_from_pc32 !== 32'h104 || wb_rd_addr32 !== 5'd3) begin
            n_err++; $display("FAIL alu_wb: got valid=%b pc=%h rd=%0d want 1 104 3", wb_valid32, wb_rd_from_pc32, wb_rd_addr32);
        end
        n_cmp++; if (stall32 !== 1'b1) begin
            n_err++; $display("FAIL lw_no_bubble: got stall=%b want 1", stall32);
        end
        step();
        ex_valid = 1'b0;
        n_cmp++; if (dm_req32 !== 1'b1 || dm_we32 !== 1'b0 || dm_be32 !== 4'hF || dm_addr32 !== 14'h800) begin
            n_err++; $display("FAIL lw_req: got req=%b we=%b be=%h addr=%h want 1 0 f 800", dm_req32, dm_we32, dm_be32, dm_addr32);
        end
        dm_ack   = 1'b1;
        dm_rdata = 64'hCAFE_F00D;
        step();
        // second memory op presented in the cycle right after the ack
        dm_ack = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b100, 64'h2001, 64'h0, 5'd6, 1'b1, 1'b0, 64'h0);
        #1;
        n_cmp++; if (wb_rd_from_mem32 !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL lw_wb: got %h want cafef00d", wb_rd_from_mem32);
        end
        n_cmp++; if (stall32 !== 1'b1) begin
            n_err++; $display("FAIL b2b_accept: got stall=%b want 1", stall32);
        end
        step();
        ex_valid = 1'b0;
        n_cmp++; if (dm_req32 !== 1'b1 || dm_be32 !== 4'b0010) begin
            n_err++; $display("FAIL lbu_req: got req=%b be=%b want 1 0010", dm_req32, dm_be32);
        end
        dm_ack   = 1'b1;
        dm_rdata = 64'h0000_9900;
        step();
        dm_ack = 1'b0;
        n_cmp++; if (wb_rd_from_mem32 !== 32'h99) begin
            n_err++; $display("FAIL lbu_wb: got %h want 00000099", wb_rd_from_mem32);
        end
    endtask

    task automatic test_reset_in_req();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 64'h2004, 64'h0, 5'd8, 1'b1, 1'b0, 64'h0);
        step();
        ex_valid = 1'b0;
        dm_ack   = 1'b0;
        n_cmp++; if (dm_req32 !== 1'b1) begin
            n_err++; $display("FAIL rstreq_pre: got req=%b want 1", dm_req32);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if ({dm_req32, wb_valid32, wb_reg_w32, wb_sel32, wb_rd_addr32, wb_rd_from_pc32,
                      wb_rd_from_mem32, wb_exc32, wb_exc_addr32, stall32} !== '0) begin
            n_err++; $display("FAIL rstreq_clear: got req=%b wb_valid=%b wb_mem=%h stall=%b want all 0",
                              dm_req32, wb_valid32, wb_rd_from_mem32, stall32);
        end
        step();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 64'h2003, 64'h0, 5'd11, 1'b1, 1'b0, 64'h0);
        #1;
        n_cmp++; if (stall32 !== 1'b1) begin
            n_err++; $display("FAIL rstreq_accept: got stall=%b want 1", stall32);
        end
        step();
        ex_valid = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = 64'h8000_0000;
        step();
        dm_ack = 1'b0;
        n_cmp++; if (wb_valid32 !== 1'b1 || wb_rd_from_mem32 !== 32'hFFFF_FF80 || wb_rd_addr32 !== 5'd11) begin
            n_err++; $display("FAIL rstreq_lb: got valid=%b data=%h rd=%0d want 1 ffffff80 11",
                              wb_valid32, wb_rd_from_mem32, wb_rd_addr32);
        end
    endtask

    initial begin
        rst      = 1'b1;
        dm_ack   = 1'b0;
        dm_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 64'h0);
        test_reset();
        test_store_byte();
        test_load_half(3'b001, 32'hFFFF_8123);
        test_load_half(3'b101, 32'h0000_8123);
        test_misaligned();
        test_xlen64_loads();
        test_back_to_back();
        test_reset_in_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
